// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam int SEG_W            = 8;
    localparam int PWM_W            = 4;
    localparam int SEL_W            = 4;
    localparam int DEF_BLANK_CYCLES = 4;
    localparam int DEF_PRESCALE_W   = 20;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Control/data bundle between the segment producers, the scan controller and the pads.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    import seg_scan_pkg::*;

    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic                         enable;
    logic [SEL_W-1:0]             tick_sel;
    logic [PWM_W-1:0]             bright;
    logic [SEG_W*NUM_DIGITS-1:0]  digit_seg;
    logic [SEG_W-1:0]             seg_out;
    logic [NUM_DIGITS-1:0]        dig_en;
    logic                         frame_start;
    logic [IDX_W-1:0]             cur_digit;

    modport master (
        output enable, tick_sel, bright, digit_seg,
        input  seg_out, dig_en, frame_start, cur_digit
    );

    modport slave (
        input  enable, tick_sel, bright, digit_seg,
        output seg_out, dig_en, frame_start, cur_digit
    );

endinterface

// File: rtl/seg_scan_tick.sv
// Free-running prescaler with a selectable tap and a two-flop rising-edge detector
// producing the single-cycle scan tick.
module seg_scan_tick
    import seg_scan_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] tick_sel_i,
    output logic             tick_o
);

    logic [PRESCALE_W-1:0]   presc_q;
    logic [(1<<SEL_W)-1:0]   tap_bits;
    logic                    sync1_q;
    logic                    sync2_q;

    // tap_bits[n] is prescaler bit PRESCALE_W-1-n; taps below bit 0 read as 0
    genvar gi;
    generate
        for (gi = 0; gi < (1 << SEL_W); gi++) begin : g_tap
            if (PRESCALE_W - 1 - gi >= 0) begin : g_real
                assign tap_bits[gi] = presc_q[PRESCALE_W-1-gi];
            end else begin : g_none
                assign tap_bits[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            presc_q <= presc_q + 1'b1;
            sync1_q <= tap_bits[tick_sel_i];
            sync2_q <= sync1_q;
        end
    end

    assign tick_o = sync1_q & ~sync2_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan controller: IDLE/BLANK/SHOW sequencing, 4-bit PWM dimming, registered pad outputs.
// Define SEG_SCAN_ACTIVE_LOW_EN for inverted (common-anode / PNP) seg_out and dig_en.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
    parameter int PRESCALE_W   = DEF_PRESCALE_W
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BC_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BC_W-1:0]  BLANK_LAST = BC_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

`ifdef SEG_SCAN_ACTIVE_LOW_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [BC_W-1:0]       blank_cnt_q, blank_cnt_d;
    logic [PWM_W-1:0]      pwm_q, pwm_d;
    logic [SEG_W-1:0]      lat_q, lat_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  frame_q, frame_d;
    logic [NUM_DIGITS-1:0] onehot_d;
    logic [SEG_W-1:0]      seg_bytes [NUM_DIGITS];
    logic                  tick;
    logic                  show_on;

    seg_scan_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick (
        .clk        (clk),
        .rst        (rst),
        .tick_sel_i (bus.tick_sel),
        .tick_o     (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            assign seg_bytes[gi] = bus.digit_seg[SEG_W*gi +: SEG_W];
            assign onehot_d[gi]  = (idx_d == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cur_q       <= '0;
            blank_cnt_q <= '0;
            pwm_q       <= '0;
            lat_q       <= '0;
            seg_q       <= {SEG_W{OUT_INV}};
            dig_q       <= {NUM_DIGITS{OUT_INV}};
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            blank_cnt_q <= blank_cnt_d;
            pwm_q       <= pwm_d;
            lat_q       <= lat_d;
            seg_q       <= seg_d ^ {SEG_W{OUT_INV}};
            dig_q       <= dig_d ^ {NUM_DIGITS{OUT_INV}};
            frame_q     <= frame_d;
        end
    end

    // The byte for the next digit is captured on BLANK entry so producers can never tear a digit.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_d       = cur_q;
        blank_cnt_d = blank_cnt_q;
        pwm_d       = pwm_q;
        lat_d       = lat_q;
        if (!bus.enable) begin
            state_d     = IDLE;
            idx_d       = '0;
            cur_d       = '0;
            blank_cnt_d = '0;
            pwm_d       = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    idx_d       = '0;
                    blank_cnt_d = '0;
                    lat_d       = seg_bytes[0];
                end
                BLANK: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        pwm_d   = '0;
                        cur_d   = idx_q;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                SHOW: begin
                    pwm_d = pwm_q + 1'b1;
                    if (tick) begin
                        state_d     = BLANK;
                        idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                        blank_cnt_d = '0;
                        lat_d       = seg_bytes[idx_d];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pad values are derived from the next state so they switch on the same edge as the FSM.
    always_comb begin
        show_on = (state_d == SHOW) && (pwm_d < bus.bright);
        seg_d   = show_on ? lat_d : '0;
        dig_d   = show_on ? onehot_d : '0;
        frame_d = (state_d == SHOW) && (state_q == BLANK) && (idx_d == '0);
    end

    assign bus.seg_out     = seg_q;
    assign bus.dig_en      = dig_q;
    assign bus.frame_start = frame_q;
    assign bus.cur_digit   = cur_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed tables plus randomized traffic against a cycle model.
module tb_seg_scan_ctrl;
    import seg_scan_pkg::*;

    localparam int ND = 4;
    localparam int BC = 4;
    localparam int PW = 20;
`ifdef SEG_SCAN_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BC),
        .PRESCALE_W   (PW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pad values normalised to active-high so one set of expectations serves both polarities.
    wire [7:0] seg_n = ACT_LOW ? ~bus.seg_out : bus.seg_out;
    wire [3:0] dig_n = ACT_LOW ? ~bus.dig_en  : bus.dig_en;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a digit is shown for whole scan slots, separated by BC dark cycles;
    // within a slot, cycle k of the slot is lit when (k mod 16) < bright.
    int unsigned m_p = 0;
    bit   m_h1 = 0, m_h2 = 0, m_tk = 0;
    int   m_mode = 0;
    int   m_digit = 0, m_blank_age = 0, m_show_age = 0, m_cur = 0;
    logic [7:0] m_lat = '0, m_seg = '0;
    logic [3:0] m_dig = '0;
    bit   m_frame = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p = 0; m_h1 = 0; m_h2 = 0; m_mode = 0; m_digit = 0; m_cur = 0;
            m_blank_age = 0; m_show_age = 0; m_lat = '0; m_seg = '0; m_dig = '0; m_frame = 0;
        end else begin
            m_tk = m_h1 && !m_h2;
            m_h2 = m_h1;
            m_h1 = ((m_p >> (PW - 1 - int'(bus.tick_sel))) & 1) != 0;
            m_p  = (m_p + 1) % (1 << PW);
            m_frame = 0;
            if (!bus.enable) begin
                m_mode = 0; m_digit = 0; m_cur = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_digit = 0; m_blank_age = 0; m_lat = bus.digit_seg[7:0];
            end else if (m_mode == 1) begin
                if (m_blank_age == BC - 1) begin
                    m_mode = 2; m_show_age = 0; m_cur = m_digit; m_frame = (m_digit == 0);
                end else begin
                    m_blank_age++;
                end
            end else begin
                m_show_age++;
                if (m_tk) begin
                    m_mode = 1; m_digit = (m_digit + 1) % ND; m_blank_age = 0;
                    m_lat = bus.digit_seg[8*m_digit +: 8];
                end
            end
            if (m_mode == 2 && (m_show_age % 16) < int'(bus.bright)) begin
                m_seg = m_lat;
                m_dig = 4'(1 << m_digit);
            end else begin
                m_seg = '0;
                m_dig = '0;
            end
        end
    end

    int m_prints = 0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (seg_n !== m_seg || dig_n !== m_dig || bus.frame_start !== m_frame ||
                bus.cur_digit !== 2'(m_cur) || $countones(dig_n) > 1 ||
                (seg_n != 0 && dig_n == 0)) begin
                errors++;
                if (m_prints < 20) begin
                    m_prints++;
                    $display("FAIL model t=%0t: seg=%h dig=%b fs=%b cur=%0d expected seg=%h dig=%b fs=%b cur=%0d",
                             $time, seg_n, dig_n, bus.frame_start, bus.cur_digit,
                             m_seg, m_dig, m_frame, m_cur);
                end
            end
        end
    end

    typedef struct {
        logic [3:0] dig;
        logic [7:0] seg;
        logic       frame;
    } vec_t;

    vec_t tbl [4];

    task automatic wait_frame(input string name, input int budget);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (bus.frame_start) seen = 1;
        end
        check({name, "_frame_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev;
        int zeros, on_cnt, bad, seen_cnt, z;
        bit found;

        tbl[0] = '{dig: 4'b0010, seg: 8'h5B, frame: 1'b0};
        tbl[1] = '{dig: 4'b0100, seg: 8'h06, frame: 1'b0};
        tbl[2] = '{dig: 4'b1000, seg: 8'h3F, frame: 1'b0};
        tbl[3] = '{dig: 4'b0001, seg: 8'h4F, frame: 1'b1};

        rst = 1'b1;
        bus.enable    = 1'b0;
        bus.tick_sel  = 4'd15;
        bus.bright    = 4'd15;
        bus.digit_seg = 32'h3F06_5B4F;
        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg_n), 32'h0);
        check("reset_dig", 32'(dig_n), 32'h0);
        rst = 1'b0;
        bus.enable = 1'b1;

        // Async reset in the middle of SHOW, observed before the next clock edge
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (dig_n != 0) found = 1;
        end
        check("t1_reach_show", 32'(found), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t1_async_seg", 32'(seg_n), 32'h0);
        check("t1_async_dig", 32'(dig_n), 32'h0);
        check("t1_async_cur", 32'(bus.cur_digit), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= BC; k++) begin
            @(negedge clk);
            check($sformatf("t1_blank%0d", k), 32'(dig_n), 32'h0);
        end
        @(negedge clk);
        check("t1_first_dig", 32'(dig_n), 32'b0001);
        check("t1_first_seg", 32'(seg_n), 32'h4F);
        check("t1_first_frame", 32'(bus.frame_start), 32'd1);
        $display("T1 reset/restart: dig=%b seg=%h", dig_n, seg_n);

        // Scan order, table driven
        prev = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            zeros = 0;
            found = 0;
            for (int c = 0; c < 300 && !found; c++) begin
                @(negedge clk);
                if (dig_n == 0) zeros++;
                else if (dig_n != prev) found = 1;
                else zeros = 0;
            end
            check($sformatf("t2_found%0d", i), 32'(found), 32'd1);
            check($sformatf("t2_dig%0d", i), 32'(dig_n), 32'(tbl[i].dig));
            check($sformatf("t2_seg%0d", i), 32'(seg_n), 32'(tbl[i].seg));
            check($sformatf("t2_frame%0d", i), 32'(bus.frame_start), 32'(tbl[i].frame));
            check($sformatf("t2_gap%0d", i), 32'(zeros >= BC), 32'd1);
            $display("T2 step %0d: dig=%b seg=%h gap=%0d frame=%b", i, dig_n, seg_n, zeros, bus.frame_start);
            prev = dig_n;
        end

        // PWM duty with a long SHOW slot, then fully dark
        bus.bright   = 4'd4;
        bus.tick_sel = 4'd13;
        wait_frame("t3a", 3000);
        wait_frame("t3b", 3000);
        on_cnt = (dig_n != 0) ? 1 : 0;
        repeat (63) begin
            @(negedge clk);
            if (dig_n != 0) on_cnt++;
        end
        check("t3_duty4", 32'(on_cnt), 32'd16);
        $display("T3 bright=4: %0d lit cycles of 64", on_cnt);
        bus.bright = 4'd0;
        on_cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (dig_n != 0 || seg_n != 0) on_cnt++;
        end
        check("t3_dark", 32'(on_cnt), 32'd0);
        $display("T3 bright=0: %0d lit cycles of 600", on_cnt);

        // No tearing when digit 0's byte changes while it is shown
        bus.bright    = 4'd15;
        bus.tick_sel  = 4'd15;
        bus.digit_seg = 32'h3F06_5B3F;
        wait_frame("t4a", 1000);
        wait_frame("t4b", 1000);
        check("t4_before", 32'(seg_n), 32'h3F);
        bus.digit_seg[7:0] = 8'h06;
        bad = 0;
        seen_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (dig_n == 4'b0001) begin
                seen_cnt++;
                if (seg_n != 8'h3F) bad++;
            end
        end
        check("t4_hold", 32'(bad), 32'd0);
        check("t4_seen", 32'(seen_cnt > 0), 32'd1);
        wait_frame("t4c", 1000);
        check("t4_after", 32'(seg_n), 32'h06);
        $display("T4 no-tear: held %0d cycles, next frame seg=%h", seen_cnt, seg_n);

        // Disable during BLANK ahead of digit 2, then restart
        z = 0;
        for (int c = 0; c < 500 && z < 2; c++) begin
            @(negedge clk);
            if (bus.cur_digit == 2'd1 && dig_n == 0) z++;
            else z = 0;
        end
        check("t5_blank2", 32'(z), 32'd2);
        bus.enable = 1'b0;
        @(negedge clk);
        check("t5_off_dig", 32'(dig_n), 32'h0);
        check("t5_off_seg", 32'(seg_n), 32'h0);
        check("t5_off_cur", 32'(bus.cur_digit), 32'h0);
        repeat (3) @(negedge clk);
        bus.enable = 1'b1;
        found = 0;
        zeros = 0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            zeros++;
            if (dig_n != 0) found = 1;
        end
        check("t5_restart_dig", 32'(dig_n), 32'b0001);
        check("t5_restart_frame", 32'(bus.frame_start), 32'd1);
        check("t5_restart_lat", 32'(zeros), 32'(BC + 1));
        $display("T5 disable/re-enable: first dig=%b after %0d cycles", dig_n, zeros);

        // Randomized traffic; the per-cycle model comparison does the checking
        for (int t = 0; t < 60; t++) begin
            bus.digit_seg = $urandom;
            bus.bright    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) bus.tick_sel = 4'($urandom_range(12, 15));
            $display("T6 txn %0d: seg=%h bright=%0d sel=%0d", t, bus.digit_seg, bus.bright, bus.tick_sel);
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 150) == 0) bus.enable = ~bus.enable;
                else if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
                if ($urandom_range(0, 40) == 0) bus.digit_seg = $urandom;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller that shares one 8-bit segment bus (7 segments plus DP) among NUM_DIGITS common-cathode digits. It sits between the per-digit segment producers (snake animation, counters) and the pads. It sequences digit enables with a programmable scan rate, inserts anti-ghosting blanking between digits, and applies 4-bit PWM brightness.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
BLANK_CYCLES, 4, all-off dead time in clk cycles between digits (1..16)
PRESCALE_W, 20, width of the free-running scan prescaler

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
enable  input  1  scan enable; low forces idle/dark
tick_sel  input  4  scan rate select; scan tick bit = prescaler[PRESCALE_W-1-tick_sel]
bright  input  4  PWM duty in sixteenths; 0 = dark
digit_seg  input  8*NUM_DIGITS  segment bytes; digit i at [8i+7:8i], bit 7 = DP
seg_out  output  8  segment bus to pads
dig_en  output  NUM_DIGITS  one-hot digit enable
frame_start  output  1  1-cycle pulse when digit 0 begins SHOW
cur_digit  output  $clog2(NUM_DIGITS)  index of the digit being driven

Behaviour:
- Reset (async, rst=1): prescaler=0, state=IDLE, index=0, pwm=0, seg_out=0, dig_en=0, frame_start=0, cur_digit=0, latched segments=0.
- Prescaler: free-running PRESCALE_W-bit up-counter, wraps; runs regardless of enable.
- Tick: selected bit passes a 2-flop edge detector; tick=1 for one cycle, 2 cycles after the selected bit rises. With tick_sel=15, PRESCALE_W=20, the period is 32 cycles.
- FSM states: IDLE, BLANK, SHOW. All outputs are registered and change on the same edge as the state transition.
- IDLE: outputs 0.
  - If enable=1, go to BLANK with index=0 on the next cycle; do not wait for a tick.
- BLANK: seg_out=0, dig_en=0.
  - Blank counter counts BLANK_CYCLES cycles. On entry, latch digit_seg for the target index.
  - On expiry, go to SHOW. pwm=0; cur_digit=index.
  - Ticks arriving during BLANK are dropped, not queued.
- SHOW: when pwm < bright, dig_en=one-hot(index) and seg_out=latched byte; otherwise both are 0.
  - pwm is a 4-bit counter that increments every cycle and wraps 15->0.
  - bright=0 gives permanently dark; bright=15 gives 15/16 duty.
  - On tick: go to BLANK, with index = index+1, wrapping NUM_DIGITS-1 -> 0.
- frame_start: asserted for exactly the first SHOW cycle when index=0.
- Input changes:
  - A digit_seg change during SHOW is not visible until that digit's next BLANK latch (no tearing).
  - A bright change takes effect on the next cycle.
- enable deassert, in any state: next cycle go to IDLE, outputs 0, index=0, pwm=0. Re-enable restarts at digit 0.
- Invariants:
  - dig_en is never more than one-hot.
  - seg_out is nonzero only while dig_en is nonzero.
  - The dig_en bit changes only after passing through at least BLANK_CYCLES cycles of all-zero.
- tick_sel change mid-scan: the edge detector may produce one spurious or missing tick. This is acceptable; the invariants above still hold.

Optional Feature:
Macro SEG_SCAN_ACTIVE_LOW_EN.
- Defined: seg_out and dig_en are inverted at the output registers for common-anode/PNP drive.
  - Reset, IDLE, BLANK and PWM-off drive all-ones.
  - The one-hot dig_en becomes one-cold.
- Undefined: active-high as specified above.
- Internal state and frame_start are unaffected either way.

Decomposition:
- Package seg_scan_pkg holds:
  - the state enum (IDLE, BLANK, SHOW)
  - SEG_W=8
  - PWM_W=4
  - SEL_W=4
  - the default BLANK_CYCLES/PRESCALE_W constants
- One natural sub-module: seg_scan_tick, containing the prescaler, the tick_sel bit mux and the 2-flop rising-edge detector, with tick as its output.
- The FSM, PWM and output registers stay in seg_scan_ctrl.

Test Plan:
1. Reset behaviour: rst=1 mid-SHOW, asynchronously between edges -> seg_out=0, dig_en=0, cur_digit=0 immediately, without waiting for clk. After release with enable=1, check BLANK for 4 cycles, then dig_en=4'b0001.
2. Scan order: tick_sel=15, bright=15, NUM_DIGITS=4, digit_seg=32'h3F06_5B4F.
   - Expect dig_en to cycle 0001->0010->0100->1000->0001.
   - seg_out shows 4F, 5B, 06, 3F in turn.
   - Each change is preceded by exactly 4 all-zero cycles.
   - frame_start fires once per 4 digits.
3. PWM: bright=4 over a 64-cycle SHOW -> exactly 4 on-cycles per 16. bright=0 -> dig_en stays 0 for the whole scan.
4. No tearing: change digit_seg[7:0] from 8'h3F to 8'h06 mid-SHOW of digit 0 -> seg_out holds 3F until digit 0's next SHOW, then shows 06.
5. Disable: enable=0 during BLANK of digit 2 -> next cycle outputs 0 and cur_digit=0. Re-enable -> the first SHOW is digit 0, with a frame_start pulse.
6. With SEG_SCAN_ACTIVE_LOW_EN defined, repeat case 2 -> dig_en sequence 1110, 1101, 1011, 0111. seg_out is the bitwise inverse of case 2, and is 8'hFF during blanking.
